// File: rtl/hex_word_tx.sv
// Prints a 32-bit word as 8 ASCII hex digits plus a line terminator,
// handing one byte at a time to a downstream UART transmitter.
module hex_word_tx #(
    parameter bit UPPERCASE = 1'b1,
    parameter bit CRLF      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_word,
    input  logic        i_stb,
    output logic        o_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_stb,
    input  logic        i_tx_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = CRLF ? 4'd9 : 4'd8;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [31:0] r_word;
    logic [31:0] w_word_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_tx_stb;
    logic        w_tx_stb_nxt;
    logic        r_busy;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else if (UPPERCASE) begin
            return 8'h41 + {4'h0, nib - 4'd10};
        end else begin
            return 8'h61 + {4'h0, nib - 4'd10};
        end
    endfunction

    function automatic logic [7:0] record_byte(input logic [31:0] word, input logic [3:0] idx);
        case (idx)
            4'd0:    return nibble_to_ascii(word[31:28]);
            4'd1:    return nibble_to_ascii(word[27:24]);
            4'd2:    return nibble_to_ascii(word[23:20]);
            4'd3:    return nibble_to_ascii(word[19:16]);
            4'd4:    return nibble_to_ascii(word[15:12]);
            4'd5:    return nibble_to_ascii(word[11:8]);
            4'd6:    return nibble_to_ascii(word[7:4]);
            4'd7:    return nibble_to_ascii(word[3:0]);
            4'd8:    return CRLF ? 8'h0D : 8'h0A;
            4'd9:    return 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction

    // Next-state, index, latched word and strobe/data decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_word_nxt    = r_word;
        w_tx_data_nxt = r_tx_data;
        w_tx_stb_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_stb) begin
                    w_word_nxt  = i_word;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    w_tx_stb_nxt  = 1'b1;
                    w_tx_data_nxt = record_byte(r_word, r_idx);
                    w_state_nxt   = GAP;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            GAP: begin
                // One idle cycle lets the downstream busy flag rise before SEND samples it.
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 4'd0;
            r_word    <= 32'h0000_0000;
            r_tx_data <= 8'h00;
            r_tx_stb  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_word    <= w_word_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_stb  <= w_tx_stb_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign o_busy    = r_busy;
    assign o_tx_data = r_tx_data;
    assign o_tx_stb  = r_tx_stb;

endmodule
